// File: rtl/air_quality_sensor_reader_if.sv
// Purpose: bundles the 3-wire sensor link and the averaged-reading outputs of the air-quality front-end.
// Latency: none, wiring only.
// Backpressure: none; the reader drives the link and the outputs are strobes and levels.
interface air_quality_sensor_reader_if;
  logic       sensor_miso;
  logic       sensor_cs_n;
  logic       sensor_sclk;
  logic [7:0] air_quality;
  logic       sample_valid;
  logic       sensor_error;
  logic       sensor_fault;

  // Reader side: drives chip select, serial clock and the result outputs.
  modport master (
    input  sensor_miso,
    output sensor_cs_n, sensor_sclk, air_quality, sample_valid, sensor_error, sensor_fault
  );

  // Sensor/consumer side: drives the data line and observes everything else.
  modport slave (
    output sensor_miso,
    input  sensor_cs_n, sensor_sclk, air_quality, sample_valid, sensor_error, sensor_fault
  );
endinterface

// File: rtl/air_quality_sensor_reader.sv
// Purpose: periodic 9-bit serial sensor read, parity check, moving average over 2^AVG_LOG2 samples, fault flag.
// Latency: 0 cycles from cs_n rising to the air_quality/strobe update (same clk edge).
// Backpressure: none; strobes are single-cycle and must be consumed when they occur.
module air_quality_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int ERR_LIMIT     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  air_quality_sensor_reader_if.master   bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int EW    = $clog2(ERR_LIMIT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
  localparam logic [3:0]    BIT_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SHIFT
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [3:0]    bit_cnt, bit_n;
  logic          high_q, high_n;
  logic          rise;
  logic          frame_done;

  logic [PW-1:0] period_cnt;
  logic [8:0]    frame_sr;
  logic [7:0]    hist [DEPTH];
  logic [SW-1:0] sum;
  logic [EW-1:0] err_cnt;

  logic          cs_n_q;
  logic          sclk_q;
  logic [7:0]    aq_q;
  logic          valid_q;
  logic          error_q;
  logic          fault_q;

  logic [7:0]    sample;
  logic          frame_good;
  logic [SW-1:0] new_sum;
  logic [EW-1:0] err_inc;

  // Data bits sit above the parity bit; even parity means the whole frame XORs to zero.
  assign sample     = frame_sr[8:1];
  assign frame_good = ~^frame_sr;
  // The sum holds 2^AVG_LOG2 bytes exactly, so dropping the oldest before adding cannot overflow.
  assign new_sum    = sum - SW'(hist[DEPTH-1]) + SW'(sample);
  assign err_inc    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + EW'(1);

  assign bus.sensor_cs_n  = cs_n_q;
  assign bus.sensor_sclk  = sclk_q;
  assign bus.air_quality  = aq_q;
  assign bus.sample_valid = valid_q;
  assign bus.sensor_error = error_q;
  assign bus.sensor_fault = fault_q;

  // Free-running conversion timer; never held off by an active frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PER_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // FSM state, slot counters and the registered link pins (decoded from next state so they are glitch-free).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      high_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      high_q  <= high_n;
      cs_n_q  <= (state_n == IDLE);
      sclk_q  <= high_n;
    end
  end

  // Next-state: SELECT settles cs_n for one divider period, then 9 low/high sclk slots.
  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    bit_n      = bit_cnt;
    high_n     = high_q;
    rise       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        high_n = 1'b0;
        if (period_cnt == PER_LAST) begin
          state_n = SELECT;
          div_n   = '0;
        end
      end
      SELECT: begin
        if (div_cnt == DIV_LAST) begin
          state_n = SHIFT;
          div_n   = '0;
          bit_n   = '0;
          high_n  = 1'b0;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!high_q) begin
            high_n = 1'b1;
            rise   = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            state_n    = IDLE;
            high_n     = 1'b0;
            frame_done = 1'b1;
          end else begin
            high_n = 1'b0;
            bit_n  = bit_cnt + 4'd1;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        high_n  = 1'b0;
      end
    endcase
  end

  // Capture on sclk rising; at frame end either fold a good sample into the average or count an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sr <= '0;
      sum      <= '0;
      err_cnt  <= '0;
      aq_q     <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (rise) begin
        frame_sr <= {frame_sr[7:0], bus.sensor_miso};
      end
      if (frame_done) begin
        if (frame_good) begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            hist[i] <= hist[i-1];
          end
          hist[0] <= sample;
          sum     <= new_sum;
          aq_q    <= new_sum[SW-1:AVG_LOG2];
          valid_q <= 1'b1;
          err_cnt <= '0;
          fault_q <= 1'b0;
        end else begin
          error_q <= 1'b1;
          err_cnt <= err_inc;
          fault_q <= (err_inc == ERR_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_air_quality_sensor_reader.sv
// Purpose: randomized and directed check of air_quality_sensor_reader against a sample-queue reference model.
// Latency: expects outputs on the cs_n-rising edge, sampled on the following falling clk edge.
// Backpressure: none; the bench plays the sensor and drives sensor_miso ahead of each sclk rise.
module tb_air_quality_sensor_reader;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
  localparam int AVG_LOG2      = 2;
  localparam int ERR_LIMIT     = 3;
  localparam int WINDOW        = 1 << AVG_LOG2;

  logic clk;
  logic rst;
  int   cyc;
  int   compared;
  int   mismatched;

  air_quality_sensor_reader_if bus ();

  air_quality_sensor_reader #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .AVG_LOG2      (AVG_LOG2),
    .ERR_LIMIT     (ERR_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release: equals the spec's cycle number when read on a falling edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    bit         timeout;
    int         fall_cyc;
    int         want_fall;
    int         low_cnt;
    int         rises;
    bit         shape_ok;
    bit         strobe_in_frame;
    bit         aq_moved;
    logic       sv;
    logic       er;
    logic       fault;
    logic [7:0] aq;
    logic       sv_next;
    logic       er_next;
  } obs_t;

  // Reference model: the last WINDOW good samples and a saturating bad-frame count.
  int         m_hist[$];
  int         m_errs;
  int         exp_fall;
  logic       exp_sv;
  logic       exp_er;
  logic       exp_fault;
  logic [7:0] exp_aq;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < WINDOW; i++) m_hist.push_back(0);
    m_errs    = 0;
    exp_aq    = 8'd0;
    exp_fault = 1'b0;
    exp_sv    = 1'b0;
    exp_er    = 1'b0;
  endtask

  task automatic model_frame(input logic [8:0] bits);
    int s;
    if ((^bits) == 1'b0) begin
      m_hist.push_front(int'(bits[8:1]));
      void'(m_hist.pop_back());
      s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      exp_aq    = 8'(s / WINDOW);
      exp_sv    = 1'b1;
      exp_er    = 1'b0;
      m_errs    = 0;
      exp_fault = 1'b0;
    end else begin
      exp_sv = 1'b0;
      exp_er = 1'b1;
      if (m_errs < ERR_LIMIT) m_errs++;
      exp_fault = (m_errs >= ERR_LIMIT);
    end
  endtask

  function automatic logic [8:0] good_frame(input logic [7:0] d);
    return {d, ^d};
  endfunction

  function automatic logic [8:0] bad_frame(input logic [7:0] d);
    return {d, ~^d};
  endfunction

  // Plays one sensor frame and records what the reader did; returns one cycle after cs_n rises.
  task automatic run_frame(input logic [8:0] bits, output obs_t o);
    int   guard;
    int   run;
    bit   first_low;
    logic prev_sclk;
    logic [7:0] aq0;
    o.timeout = 0; o.fall_cyc = -1; o.want_fall = exp_fall; o.low_cnt = 0; o.rises = 0;
    o.shape_ok = 1; o.strobe_in_frame = 0; o.aq_moved = 0;
    o.sv = 0; o.er = 0; o.fault = 0; o.aq = 0; o.sv_next = 0; o.er_next = 0;
    exp_fall += SAMPLE_PERIOD;
    bus.sensor_miso = bits[8];
    guard = 0;
    while (bus.sensor_cs_n !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      o.timeout = 1;
      return;
    end
    o.fall_cyc = cyc;
    aq0        = bus.air_quality;
    prev_sclk  = 1'b0;
    run        = 0;
    first_low  = 1;
    guard      = 0;
    while (bus.sensor_cs_n === 1'b0 && guard < 200) begin
      o.low_cnt++;
      if (bus.sensor_sclk !== prev_sclk) begin
        if (prev_sclk === 1'b0) begin
          if (run != (first_low ? 2 * CLK_DIV : CLK_DIV)) o.shape_ok = 0;
          first_low = 0;
          o.rises++;
        end else if (run != CLK_DIV) begin
          o.shape_ok = 0;
        end
        run = 0;
      end
      run++;
      prev_sclk = bus.sensor_sclk;
      if (bus.sensor_sclk === 1'b0 && o.rises < 9) bus.sensor_miso = bits[8 - o.rises];
      if (bus.sample_valid !== 1'b0 || bus.sensor_error !== 1'b0) o.strobe_in_frame = 1;
      if (bus.air_quality !== aq0) o.aq_moved = 1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      o.timeout = 1;
      return;
    end
    if (!(prev_sclk === 1'b1 && run == CLK_DIV && bus.sensor_sclk === 1'b0)) o.shape_ok = 0;
    o.sv    = bus.sample_valid;
    o.er    = bus.sensor_error;
    o.fault = bus.sensor_fault;
    o.aq    = bus.air_quality;
    bus.sensor_miso = 1'b0;
    @(negedge clk);
    o.sv_next = bus.sample_valid;
    o.er_next = bus.sensor_error;
  endtask

  task automatic test_reset();
    int bad_cycles;
    rst = 1'b1;
    bus.sensor_miso = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_fall   = SAMPLE_PERIOD;
    bad_cycles = 0;
    for (int i = 0; i < SAMPLE_PERIOD; i++) begin
      if ({bus.sensor_cs_n, bus.sensor_sclk, bus.air_quality, bus.sample_valid,
           bus.sensor_error, bus.sensor_fault} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0})
        bad_cycles++;
      @(negedge clk);
    end
    compared++;
    if (bad_cycles !== 0) begin
      mismatched++;
      $display("FAIL reset_hold: %0d cycles of 0..99 left reset values, required 0", bad_cycles);
    end
  endtask

  task automatic test_frame_timing();
    obs_t       o;
    logic [8:0] f;
    f = good_frame(8'h00);
    run_frame(f, o);
    model_frame(f);
    compared++;
    if (o.timeout || o.fall_cyc !== o.want_fall) begin
      mismatched++;
      $display("FAIL timing_fall: cs_n fell at cycle %0d (timeout %0d), required %0d", o.fall_cyc, o.timeout, o.want_fall);
    end
    compared++;
    if (o.low_cnt !== 19 * CLK_DIV) begin
      mismatched++;
      $display("FAIL timing_cs_low: cs_n low %0d cycles, required %0d", o.low_cnt, 19 * CLK_DIV);
    end
    compared++;
    if (o.rises !== 9 || !o.shape_ok) begin
      mismatched++;
      $display("FAIL timing_sclk: %0d rises shape_ok=%0d, required 9 rises shape_ok=1", o.rises, o.shape_ok);
    end
    compared++;
    if ({o.sv, o.er, o.sv_next, o.strobe_in_frame} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL timing_strobe: sv/er/sv_next/in_frame=%b%b%b%b, required 1000", o.sv, o.er, o.sv_next, o.strobe_in_frame);
    end
  endtask

  task automatic test_ramp();
    obs_t       o;
    logic [7:0] want [4] = '{8'd30, 8'd60, 8'd90, 8'd120};
    for (int i = 0; i < 4; i++) begin
      run_frame(good_frame(8'd120), o);
      model_frame(good_frame(8'd120));
      compared++;
      if ({o.timeout, o.sv, o.er, o.sv_next, o.aq} !== {1'b0, 1'b1, 1'b0, 1'b0, want[i]}) begin
        mismatched++;
        $display("FAIL ramp[%0d]: to/sv/er/sv_next=%b%b%b%b aq=%0d, required 0100 aq=%0d",
                 i, o.timeout, o.sv, o.er, o.sv_next, o.aq, want[i]);
      end
    end
  endtask

  task automatic test_window();
    obs_t o;
    run_frame(good_frame(8'd20), o);
    model_frame(good_frame(8'd20));
    compared++;
    if ({o.timeout, o.sv, o.aq} !== {1'b0, 1'b1, 8'd95}) begin
      mismatched++;
      $display("FAIL window_20: to/sv=%b%b aq=%0d, required 01 aq=95", o.timeout, o.sv, o.aq);
    end
    run_frame({8'hC8, 1'b1}, o);
    model_frame({8'hC8, 1'b1});
    compared++;
    if ({o.timeout, o.sv, o.aq} !== {1'b0, 1'b1, 8'd115}) begin
      mismatched++;
      $display("FAIL window_200: to/sv=%b%b aq=%0d, required 01 aq=115", o.timeout, o.sv, o.aq);
    end
  endtask

  task automatic test_parity_error();
    obs_t o;
    run_frame({8'h32, 1'b0}, o);
    model_frame({8'h32, 1'b0});
    compared++;
    if ({o.timeout, o.sv, o.er, o.er_next, o.fault, o.aq_moved, o.aq} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd115}) begin
      mismatched++;
      $display("FAIL parity_err: to/sv/er/er_next/fault/moved=%b%b%b%b%b%b aq=%0d, required 001000 aq=115",
               o.timeout, o.sv, o.er, o.er_next, o.fault, o.aq_moved, o.aq);
    end
  endtask

  task automatic test_fault();
    obs_t       o;
    logic [8:0] f;
    f = good_frame(8'($urandom_range(0, 255)));
    run_frame(f, o);
    model_frame(f);
    for (int i = 0; i < 3; i++) begin
      f = bad_frame(8'($urandom_range(0, 255)));
      run_frame(f, o);
      model_frame(f);
      compared++;
      if ({o.timeout, o.er, o.sv, o.fault, o.aq} !== {1'b0, 1'b1, 1'b0, (i == 2), exp_aq}) begin
        mismatched++;
        $display("FAIL fault_bad[%0d]: to/er/sv/fault=%b%b%b%b aq=%0d, required 010%0d aq=%0d",
                 i, o.timeout, o.er, o.sv, o.fault, o.aq, (i == 2), exp_aq);
      end
    end
    run_frame(good_frame(8'd50), o);
    model_frame(good_frame(8'd50));
    compared++;
    if ({o.timeout, o.sv, o.er, o.fault, o.aq} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_aq}) begin
      mismatched++;
      $display("FAIL fault_clear: to/sv/er/fault=%b%b%b%b aq=%0d, required 0100 aq=%0d",
               o.timeout, o.sv, o.er, o.fault, o.aq, exp_aq);
    end
  endtask

  task automatic test_random();
    obs_t       o;
    logic [8:0] f;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0) ? bad_frame(d) : good_frame(d);
      run_frame(f, o);
      model_frame(f);
      compared++;
      if ({o.timeout, o.sv, o.er, o.fault, o.aq} !== {1'b0, exp_sv, exp_er, exp_fault, exp_aq}) begin
        mismatched++;
        $display("FAIL random[%0d] frame %h: to/sv/er/fault=%b%b%b%b aq=%0d, required 0%b%b%b aq=%0d",
                 i, f, o.timeout, o.sv, o.er, o.fault, o.aq, exp_sv, exp_er, exp_fault, exp_aq);
      end
      compared++;
      if (o.fall_cyc !== o.want_fall || o.low_cnt !== 19 * CLK_DIV || o.rises !== 9 || !o.shape_ok ||
          o.strobe_in_frame || o.aq_moved || o.sv_next || o.er_next) begin
        mismatched++;
        $display("FAIL random_timing[%0d]: fall=%0d low=%0d rises=%0d shape=%0d inframe=%0d moved=%0d next=%b%b, required fall=%0d low=%0d rises=9 shape=1 others 0",
                 i, o.fall_cyc, o.low_cnt, o.rises, o.shape_ok, o.strobe_in_frame, o.aq_moved,
                 o.sv_next, o.er_next, o.want_fall, 19 * CLK_DIV);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    obs_t       o;
    int         guard;
    int         rises;
    logic       prev;
    logic [8:0] f;
    guard = 0;
    rises = 0;
    prev  = 1'b0;
    while (bus.sensor_cs_n !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    while (!(rises == 4 && bus.sensor_sclk === 1'b1) && guard < 800) begin
      @(negedge clk);
      guard++;
      if (bus.sensor_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = bus.sensor_sclk;
    end
    compared++;
    if (guard >= 800) begin
      mismatched++;
      $display("FAIL midreset_reach: 4th sclk high phase not seen, rises=%0d required 4", rises);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.sensor_cs_n, bus.sensor_sclk, bus.air_quality, bus.sample_valid, bus.sensor_error,
         bus.sensor_fault} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL midreset_outputs: cs_n/sclk=%b%b aq=%0d sv/er/fault=%b%b%b, required 10 aq=0 000",
               bus.sensor_cs_n, bus.sensor_sclk, bus.air_quality, bus.sample_valid,
               bus.sensor_error, bus.sensor_fault);
    end
    rst = 1'b0;
    model_reset();
    exp_fall = SAMPLE_PERIOD;
    f = good_frame(8'($urandom_range(0, 255)));
    run_frame(f, o);
    model_frame(f);
    compared++;
    if (o.timeout || o.fall_cyc !== SAMPLE_PERIOD) begin
      mismatched++;
      $display("FAIL midreset_restart: cs_n fell at cycle %0d (timeout %0d), required %0d",
               o.fall_cyc, o.timeout, SAMPLE_PERIOD);
    end
    compared++;
    if ({o.sv, o.er, o.fault, o.aq} !== {exp_sv, exp_er, exp_fault, exp_aq}) begin
      mismatched++;
      $display("FAIL midreset_frame: sv/er/fault=%b%b%b aq=%0d, required %b%b%b aq=%0d",
               o.sv, o.er, o.fault, o.aq, exp_sv, exp_er, exp_fault, exp_aq);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_fall   = SAMPLE_PERIOD;
    rst        = 1'b1;
    bus.sensor_miso = 1'b0;
    test_reset();
    test_frame_timing();
    test_ramp();
    test_window();
    test_parity_error();
    test_fault();
    test_random();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
